// File: rtl/led_anim_pkg.sv
// Shared mode and direction encodings for the LED pattern generator.
package led_anim_pkg;

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'd0,
      MODE_ROTATE = 2'd1,
      MODE_FILL   = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Enabled-cycle counter that raises a step strobe every iDIV+1 enabled cycles.
module tick_prescaler #(
   parameter int PRESC_W = 26
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iEN,
   input  logic               iCLR,
   input  logic [PRESC_W-1:0] iDIV,
   output logic               oSTEP
);

   logic [PRESC_W-1:0] count_r;
   logic [PRESC_W-1:0] count_nxt_s;
   logic               due_s;

   // >= rather than == so lowering iDIV below the count still fires promptly
   always_comb begin
      due_s = (count_r >= iDIV);
      oSTEP = iEN & due_s;
   end

   // Next count: clear wins, then wrap on step, else advance only while enabled
   always_comb begin
      count_nxt_s = count_r;
      if (iCLR) begin
         count_nxt_s = {PRESC_W{1'b0}};
      end else if (iEN) begin
         if (due_s) begin
            count_nxt_s = {PRESC_W{1'b0}};
         end else begin
            count_nxt_s = count_r + {{(PRESC_W-1){1'b0}}, 1'b1};
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Count register
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         count_r <= {PRESC_W{1'b0}};
      end else begin
         count_r <= count_nxt_s;
      end
   end

endmodule

// File: rtl/led_animator.sv
// Parametrised LED pattern generator: bounce, rotate, fill/drain and blink,
// stepped by an internal prescaler; all outputs come straight from registers.
module led_animator
   import led_anim_pkg::*;
#(
   parameter int WIDTH   = 18,
   parameter int PRESC_W = 26
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iEN,
   input  logic [1:0]         iMODE,
   input  logic [PRESC_W-1:0] iDIV,
   output logic [WIDTH-1:0]   oLEDS,
   output logic               oDIR,
   output logic               oTICK
);

   localparam logic [WIDTH-1:0] PAT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] PAT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] PAT_ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0] leds_r, leds_nxt_s, step_leds_s;
   logic             dir_r, dir_nxt_s, step_dir_s;
   logic             tick_r, tick_nxt_s;
   mode_t            mode_r, mode_nxt_s;
   logic             reload_s;
   logic             step_s;

   function automatic logic [WIDTH-1:0] init_pattern(input mode_t m);
      logic [WIDTH-1:0] p;
      case (m)
         MODE_BOUNCE: p = PAT_ONE;
         MODE_ROTATE: p = PAT_ONE;
         MODE_FILL:   p = PAT_ZERO;
         MODE_BLINK:  p = PAT_ONES;
         default:     p = PAT_ONE;
      endcase
      return p;
   endfunction

   assign reload_s = (iMODE != mode_r);

   tick_prescaler #(
      .PRESC_W(PRESC_W)
   ) u_presc (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .iEN   (iEN),
      .iCLR  (reload_s),
      .iDIV  (iDIV),
      .oSTEP (step_s)
   );

   // Pattern and direction one step ahead, per stored mode
   always_comb begin
      step_leds_s = leds_r;
      step_dir_s  = dir_r;
      case (mode_r)
         MODE_BOUNCE: begin
            if (dir_r == DIR_UP) begin
               step_leds_s = {leds_r[WIDTH-2:0], 1'b0};
               step_dir_s  = step_leds_s[WIDTH-1] ? DIR_DOWN : DIR_UP;
            end else begin
               step_leds_s = {1'b0, leds_r[WIDTH-1:1]};
               step_dir_s  = step_leds_s[0] ? DIR_UP : DIR_DOWN;
            end
         end
         MODE_ROTATE: begin
            step_leds_s = {leds_r[WIDTH-2:0], leds_r[WIDTH-1]};
            step_dir_s  = DIR_UP;
         end
         MODE_FILL: begin
            if (dir_r == DIR_UP) begin
               step_leds_s = {leds_r[WIDTH-2:0], 1'b1};
               step_dir_s  = (step_leds_s == PAT_ONES) ? DIR_DOWN : DIR_UP;
            end else begin
               step_leds_s = {leds_r[WIDTH-2:0], 1'b0};
               step_dir_s  = (step_leds_s == PAT_ZERO) ? DIR_UP : DIR_DOWN;
            end
         end
         MODE_BLINK: begin
            step_leds_s = ~leds_r;
            step_dir_s  = DIR_UP;
         end
         default: begin
            step_leds_s = leds_r;
            step_dir_s  = dir_r;
         end
      endcase
   end

   // Next state: a mode reload beats a step and applies even while frozen
   always_comb begin
      leds_nxt_s = leds_r;
      dir_nxt_s  = dir_r;
      mode_nxt_s = mode_r;
      tick_nxt_s = 1'b0;
      if (reload_s) begin
         mode_nxt_s = mode_t'(iMODE);
         leds_nxt_s = init_pattern(mode_t'(iMODE));
         dir_nxt_s  = DIR_UP;
         tick_nxt_s = 1'b0;
      end else if (step_s) begin
         leds_nxt_s = step_leds_s;
         dir_nxt_s  = step_dir_s;
         tick_nxt_s = 1'b1;
      end else begin
         tick_nxt_s = 1'b0;
      end
   end

   // State register
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         leds_r <= PAT_ONE;
         dir_r  <= DIR_UP;
         tick_r <= 1'b0;
         mode_r <= MODE_BOUNCE;
      end else begin
         leds_r <= leds_nxt_s;
         dir_r  <= dir_nxt_s;
         tick_r <= tick_nxt_s;
         mode_r <= mode_nxt_s;
      end
   end

   // Outputs
   always_comb begin
      oLEDS = leds_r;
      oDIR  = dir_r;
      oTICK = tick_r;
   end

endmodule

// File: tb/tb_led_animator.sv
// Directed bench for led_animator at WIDTH=4 with hand-computed expectations.
module tb_led_animator;

   localparam int W  = 4;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [1:0]    mode;
   logic [PW-1:0] div;
   logic [W-1:0]  leds;
   logic          dir;
   logic          tick;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_animator #(
      .WIDTH  (W),
      .PRESC_W(PW)
   ) dut (
      .iCLK  (clk),
      .iRST_N(rst_n),
      .iEN   (en),
      .iMODE (mode),
      .iDIV  (div),
      .oLEDS (leds),
      .oDIR  (dir),
      .oTICK (tick)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [W-1:0] l, input logic d, input logic t);
      check({tag, "_leds"}, 32'(leds), 32'(l));
      check({tag, "_dir"},  32'(dir),  32'(d));
      check({tag, "_tick"}, 32'(tick), 32'(t));
   endtask

   logic [W-1:0] bounce_l [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
   logic         bounce_d [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [W-1:0] presc_l  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100};
   logic         presc_d  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [W-1:0] fill_l   [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                  4'b1100, 4'b1000, 4'b0000, 4'b0001};
   logic         fill_d   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [W-1:0] rot_l    [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      mode  = 2'd0;
      div   = 8'd0;
      #12;
      expect_state("reset", 4'b0001, 1'b0, 1'b0);
      rst_n = 1'b1;
      en    = 1'b1;

      // BOUNCE sweep at iDIV=0
      for (int i = 0; i < 7; i++) begin
         cyc();
         expect_state($sformatf("bounce%0d", i), bounce_l[i], bounce_d[i], 1'b1);
      end

      // Prescaler at iDIV=3, count starts at 0
      div = 8'd3;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         expect_state($sformatf("presc%0d", i), presc_l[i/4], presc_d[i/4], (i % 4 == 0) ? 1'b1 : 1'b0);
      end
      cyc();
      cyc();
      check("presc_cnt2_tick", 32'(tick), 32'd0);
      div = 8'd1;
      cyc();
      expect_state("lower_div", 4'b0010, 1'b1, 1'b1);
      cyc();
      check("div1_wait_tick", 32'(tick), 32'd0);
      cyc();
      expect_state("div1_step", 4'b0001, 1'b0, 1'b1);

      // Mode change on the cycle a step is due
      div = 8'd3;
      cyc();
      cyc();
      cyc();
      check("pre_reload_tick", 32'(tick), 32'd0);
      mode = 2'd3;
      cyc();
      expect_state("blink_load", 4'b1111, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         expect_state($sformatf("blink_wait%0d", i), 4'b1111, 1'b0, 1'b0);
      end
      cyc();
      expect_state("blink_step", 4'b0000, 1'b0, 1'b1);

      // FILL at iDIV=0
      div  = 8'd0;
      mode = 2'd2;
      cyc();
      expect_state("fill_load", 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         cyc();
         expect_state($sformatf("fill%0d", i), fill_l[i], fill_d[i], 1'b1);
      end

      // ROTATE
      mode = 2'd1;
      cyc();
      expect_state("rot_load", 4'b0001, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         expect_state($sformatf("rot%0d", i), rot_l[i], 1'b0, 1'b1);
      end

      // Freeze with count=2, then resume to show the count was held
      div = 8'd3;
      cyc();
      cyc();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         expect_state($sformatf("frz%0d", i), 4'b0001, 1'b0, 1'b0);
      end
      en = 1'b1;
      cyc();
      expect_state("resume_wait", 4'b0001, 1'b0, 1'b0);
      cyc();
      expect_state("resume_step", 4'b0010, 1'b0, 1'b1);

      // Reload while frozen, then resume from a cleared count
      en   = 1'b0;
      mode = 2'd2;
      cyc();
      expect_state("frz_reload", 4'b0000, 1'b0, 1'b0);
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         expect_state($sformatf("reen_wait%0d", i), 4'b0000, 1'b0, 1'b0);
      end
      cyc();
      expect_state("reen_step", 4'b0001, 1'b0, 1'b1);

      // Async reset mid-FILL while draining
      div = 8'd0;
      for (int i = 0; i < 5; i++) cyc();
      expect_state("pre_rst", 4'b1100, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      expect_state("async_rst", 4'b0001, 1'b0, 1'b0);
      #3;
      rst_n = 1'b1;
      cyc();
      expect_state("post_rst_reload", 4'b0000, 1'b0, 1'b0);
      cyc();
      expect_state("post_rst_step", 4'b0001, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_animator.md
# led_animator

Parametrised LED pattern generator for the DE2 board-test top level. It is the successor to the fixed 18-LED ping-pong animation. Width and speed are parameters. Four selectable patterns are supported, with an internal prescaler, enable/freeze, asynchronous reset, and a tick strobe. It drives LEDR/LEDG banks from CLOCK_50 directly, so no external clock divider is needed.

## Interface
- `WIDTH`, default 18: number of LEDs driven; must be ≥ 2.
- `PRESC_W`, default 26: prescaler counter width, and width of `iDIV`.
- `iCLK`, input, 1: system clock (CLOCK_50).
- `iRST_N`, input, 1: asynchronous, active-low reset.
- `iEN`, input, 1: 1 runs the animation; 0 freezes the prescaler and the pattern.
- `iMODE`, input, 2: pattern select. 0 = BOUNCE, 1 = ROTATE, 2 = FILL, 3 = BLINK.
- `iDIV`, input, PRESC_W: a step occurs every `iDIV+1` enabled cycles.
- `oLEDS`, output, WIDTH: current pattern; registered.
- `oDIR`, output, 1: 0 = moving/filling toward MSB; 1 = toward LSB/draining; registered.
- `oTICK`, output, 1: one-cycle pulse, high in the cycle after the step edge, coincident with the new `oLEDS`; registered.

## Operation
**Reset values:** `oLEDS` = 1, `oDIR` = 0, `oTICK` = 0, prescaler count = 0, stored mode = BOUNCE.

**Prescaler**
- While `iEN` = 1, the count increments each cycle.
- When count ≥ `iDIV`, the count clears to 0 and a step occurs.
- The ≥ compare means that if `iDIV` is lowered below the current count, a step fires on the next edge.
- `iDIV` = 0 steps every cycle.

**Mode change**
- `iMODE` is compared against the stored mode each cycle.
- On a difference, on the next edge: load the new mode's initial pattern, set `oDIR` = 0, clear the prescaler, store the new mode, and keep `oTICK` = 0.
- A reload takes precedence over a step in the same cycle.
- A reload is applied even when `iEN` = 0.

**Patterns and initial values**
- **BOUNCE**, initial one-hot bit 0.
  - Shift left while `oDIR` = 0 and right while `oDIR` = 1.
  - The direction flips on the step that lands on bit WIDTH-1 or bit 0, so the end LEDs are lit for exactly one step.
  - Period is 2·(WIDTH-1) steps.
- **ROTATE**, initial one-hot bit 0.
  - Rotates left; bit WIDTH-1 wraps to bit 0.
  - `oDIR` stays 0.
  - Period is WIDTH steps.
- **FILL**, initial all zeros.
  - Filling (`oDIR` = 0): shift left, inserting 1 at LSB. On reaching all ones, set `oDIR` = 1.
  - Draining: shift left, inserting 0 at LSB. On reaching all zeros, set `oDIR` = 0.
  - Period is 2·WIDTH steps.
- **BLINK**, initial all ones. Each step inverts all bits; `oDIR` stays 0.

**Freeze:** `iEN` = 0 holds count, pattern and `oDIR`, and forces `oTICK` = 0.

**Reset mid-operation:** outputs go to their reset values immediately (asynchronously). If `iMODE` ≠ BOUNCE after release, a reload follows on the first clock edge.

## Timing
- Each step updates `oLEDS`, `oDIR` and `oTICK` = 1 on the same edge.
- Step period is `iDIV+1` cycles of `iCLK` with `iEN` high.
- From enable asserted with count = 0 to the first step, latency is `iDIV+1` edges.
- A mode change takes effect one edge after `iMODE` changes. The first step of the new mode follows `iDIV+1` edges later.
- All outputs are registered. There is no combinational path from inputs to outputs.
- The ≥ compare in the prescaler is the only wide compare and is single-cycle at 50 MHz for PRESC_W ≤ 32.

## Structure
- Package `led_anim_pkg` holds:
  - mode constants `MODE_BOUNCE`, `MODE_ROTATE`, `MODE_FILL`, `MODE_BLINK` (2 bits);
  - direction constants `DIR_UP` = 0, `DIR_DOWN` = 1.
- Sub-module `tick_prescaler`, parameter PRESC_W, ports: `iCLK`, `iRST_N`, `iEN`, `iCLR`, `iDIV`, and output `oSTEP`.
  - `oSTEP` is combinational from the count compare.
  - Its count register is the only state in the sub-module.
- `led_animator` holds the pattern register, the direction bit, the stored mode and the `oTICK` register, plus the next-pattern mux per mode.

## Test plan
All scenarios use WIDTH = 4.
- **BOUNCE sweep:** reset, `iMODE` = 0, `iDIV` = 0, `iEN` = 1.
  - `oLEDS` must step 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
  - `oDIR` must read 1 from the 1000 step through the step before 0001.
  - `oTICK` must be high every cycle.
- **Prescaler:** `iDIV` = 3.
  - `oTICK` must pulse exactly every 4th cycle, with `oLEDS` changing only on those cycles.
  - Lowering `iDIV` from 3 to 1 while count = 2 must produce a step on the next edge.
- **FILL and ROTATE:**
  - FILL with `iDIV` = 0 must give 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001. `oDIR` must be 1 from the 1111 step until 0000.
  - ROTATE must give 0001, 0010, 0100, 1000, 0001.
- **Mode change precedence:** in BOUNCE with `iDIV` = 3, change `iMODE` to 3 on the cycle a step is due.
  - On the next edge `oLEDS` must be 1111 and `oTICK` = 0.
  - After 4 further cycles `oLEDS` must be 0000 with `oTICK` pulsed.
- **Freeze and reload:** deassert `iEN` mid-pattern.
  - `oLEDS`, `oDIR` and count must hold for 10 cycles with `oTICK` = 0.
  - Changing `iMODE` to 2 while frozen must still load 0000.
  - Re-enabling must resume with the first step after `iDIV+1` cycles.
- **Async reset:** assert `iRST_N` low between clock edges in FILL mode.
  - `oLEDS` must become 0001 and `oDIR` 0 without a clock edge.
  - After release with `iMODE` = 2, `oLEDS` must become 0000 on the first edge.
